// File: rtl/mandel_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mandel_pkg
//  Description : Shared types and constants for the Mandelbrot pixel path.
//                Scheduler state encoding, coordinate stepper commands,
//                screen geometry defaults and Q-format widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package mandel_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int Q_FRAC   = 16;
    localparam int COORD_W  = 32;
    localparam int DEPTH_W  = 10;
    localparam int X_W      = 10;
    localparam int Y_W      = 9;

    // Pixel scheduler states
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_CLR  = 3'd2,
        WAIT_DONE = 3'd3,
        EMIT      = 3'd4
    } sched_state_t;

    // Coordinate stepper commands
    typedef enum logic [1:0] {
        STEP_HOLD      = 2'd0,
        STEP_LOAD      = 2'd1,
        STEP_NEXT_X    = 2'd2,
        STEP_NEXT_LINE = 2'd3
    } step_cmd_t;

endpackage
`default_nettype wire

// File: rtl/pixel_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_scheduler_if
//  Description : Bus bundle between the pixel scheduler, the depth
//                calculator (start/done handshake) and colour mapping
//                (valid/ready pixel stream).
//                master : scheduler side
//                slave  : calculator / downstream side
//  Revision    : 1.0 - initial release
// ============================================================================
interface pixel_scheduler_if;
    import mandel_pkg::*;

    // Depth calculator handshake
    logic                   calc_start;
    logic [X_W-1:0]         calc_x;
    logic [Y_W-1:0]         calc_y;
    logic [COORD_W-1:0]     calc_re_c;
    logic [COORD_W-1:0]     calc_im_c;
    logic                   calc_done;
    logic [DEPTH_W-1:0]     calc_depth;

    // Output pixel stream
    logic                   pix_valid;
    logic                   pix_ready;
    logic [X_W-1:0]         pix_x;
    logic [Y_W-1:0]         pix_y;
    logic [DEPTH_W-1:0]     pix_depth;
    logic                   pix_sof;
    logic                   pix_eol;

    modport master (
        output calc_start, calc_x, calc_y, calc_re_c, calc_im_c,
        input  calc_done, calc_depth,
        output pix_valid, pix_x, pix_y, pix_depth, pix_sof, pix_eol,
        input  pix_ready
    );

    modport slave (
        input  calc_start, calc_x, calc_y, calc_re_c, calc_im_c,
        output calc_done, calc_depth,
        input  pix_valid, pix_x, pix_y, pix_depth, pix_sof, pix_eol,
        output pix_ready
    );

endinterface
`default_nettype wire

// File: rtl/coord_stepper.sv
`default_nettype none
// ============================================================================
//  Module      : coord_stepper
//  Description : Incremental complex-constant generator. Holds the running
//                real/imaginary accumulators plus the latched real origin and
//                step. Commands:
//                  LOAD      - latch origin/step, accumulators = origin
//                  NEXT_X    - re += step
//                  NEXT_LINE - re = latched origin, im -= step
//                All arithmetic wraps in 32-bit two's complement.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                i_cmd             - stepper command
//                i_re_origin/i_im_origin/i_step - values taken on LOAD
//                o_re_acc/o_im_acc - current complex constant
//  Revision    : 1.0 - initial release
// ============================================================================
module coord_stepper
    import mandel_pkg::*;
(
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire step_cmd_t          i_cmd,
    input  wire logic [COORD_W-1:0] i_re_origin,
    input  wire logic [COORD_W-1:0] i_im_origin,
    input  wire logic [COORD_W-1:0] i_step,
    output logic      [COORD_W-1:0] o_re_acc,
    output logic      [COORD_W-1:0] o_im_acc
);

    logic [COORD_W-1:0] re_acc_q, re_acc_d;
    logic [COORD_W-1:0] im_acc_q, im_acc_d;
    logic [COORD_W-1:0] re_org_q, re_org_d;
    logic [COORD_W-1:0] step_q,   step_d;

    always_comb begin
        re_acc_d = re_acc_q;
        im_acc_d = im_acc_q;
        re_org_d = re_org_q;
        step_d   = step_q;
        case (i_cmd)
            STEP_LOAD: begin
                re_org_d = i_re_origin;
                step_d   = i_step;
                re_acc_d = i_re_origin;
                im_acc_d = i_im_origin;
            end
            STEP_NEXT_X: begin
                re_acc_d = re_acc_q + step_q;
            end
            STEP_NEXT_LINE: begin
                // Imaginary axis decreases downward
                re_acc_d = re_org_q;
                im_acc_d = im_acc_q - step_q;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            re_acc_q <= '0;
            im_acc_q <= '0;
            re_org_q <= '0;
            step_q   <= '0;
        end else begin
            re_acc_q <= re_acc_d;
            im_acc_q <= im_acc_d;
            re_org_q <= re_org_d;
            step_q   <= step_d;
        end
    end

    assign o_re_acc = re_acc_q;
    assign o_im_acc = im_acc_q;

endmodule
`default_nettype wire

// File: rtl/pixel_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_scheduler
//  Description : Raster-scans one frame, steps each pixel's complex constant,
//                drives one depth calculator via start/done and emits the
//                finished pixels on a valid/ready stream.
//  Ports       : sysclk, reset       - clock, synchronous active-high reset
//                frame_start         - begin a frame (taken in IDLE only)
//                re_origin/im_origin - constant of pixel (0,0), Q-format
//                step                - per-pixel increment, Q-format
//                sched_if (master)   - calculator handshake + pixel stream
//                busy                - high outside IDLE
//                frame_done          - pulse after the last pixel is accepted
//                frame_cycles        - busy-cycle count of the last frame
//  Options     : PIXEL_SCHED_PERF_EN - enables the frame_cycles counter;
//                otherwise frame_cycles is tied to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module pixel_scheduler
    import mandel_pkg::*;
#(
    parameter int WIDTH  = SCREEN_W,
    parameter int HEIGHT = SCREEN_H,
    parameter int FRAC   = Q_FRAC
) (
    input  wire logic               sysclk,
    input  wire logic               reset,
    input  wire logic               frame_start,
    input  wire logic [COORD_W-1:0] re_origin,
    input  wire logic [COORD_W-1:0] im_origin,
    input  wire logic [COORD_W-1:0] step,
    pixel_scheduler_if.master       sched_if,
    output logic                    busy,
    output logic                    frame_done,
    output logic      [31:0]        frame_cycles
);

    // FRAC only changes how the coordinates are interpreted
    localparam int c_frac_unused = FRAC;

    localparam logic [X_W-1:0] c_x_last = X_W'(WIDTH - 1);
    localparam logic [Y_W-1:0] c_y_last = Y_W'(HEIGHT - 1);

    sched_state_t           state_q, state_d;
    logic [X_W-1:0]         x_q, x_d;
    logic [Y_W-1:0]         y_q, y_d;
    logic                   calc_start_q, calc_start_d;
    logic                   pix_valid_q, pix_valid_d;
    logic [X_W-1:0]         pix_x_q, pix_x_d;
    logic [Y_W-1:0]         pix_y_q, pix_y_d;
    logic [DEPTH_W-1:0]     pix_depth_q, pix_depth_d;
    logic                   pix_sof_q, pix_sof_d;
    logic                   pix_eol_q, pix_eol_d;
    logic                   busy_q, busy_d;
    logic                   frame_done_q, frame_done_d;

    step_cmd_t              w_step_cmd;
    logic [COORD_W-1:0]     w_re_acc;
    logic [COORD_W-1:0]     w_im_acc;
    logic                   w_frame_accept;

    assign w_frame_accept = (state_q == IDLE) && frame_start;

    // ------------------------------------------------------------------
    // Next-state / next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        calc_start_d = 1'b0;
        frame_done_d = 1'b0;
        pix_valid_d  = pix_valid_q;
        pix_x_d      = pix_x_q;
        pix_y_d      = pix_y_q;
        pix_depth_d  = pix_depth_q;
        pix_sof_d    = pix_sof_q;
        pix_eol_d    = pix_eol_q;
        w_step_cmd   = STEP_HOLD;

        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    w_step_cmd   = STEP_LOAD;
                    x_d          = '0;
                    y_d          = '0;
                    calc_start_d = 1'b1;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT_CLR;
            end
            WAIT_CLR: begin
                // A done still high from the previous pixel must fall first
                if (!sched_if.calc_done) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (sched_if.calc_done) begin
                    pix_depth_d = sched_if.calc_depth;
                    pix_x_d     = x_q;
                    pix_y_d     = y_q;
                    pix_sof_d   = (x_q == '0) && (y_q == '0);
                    pix_eol_d   = (x_q == c_x_last);
                    pix_valid_d = 1'b1;
                    state_d     = EMIT;
                end
            end
            EMIT: begin
                // Nothing new is started until this pixel is taken
                if (sched_if.pix_ready) begin
                    pix_valid_d = 1'b0;
                    if (x_q < c_x_last) begin
                        x_d          = x_q + X_W'(1);
                        w_step_cmd   = STEP_NEXT_X;
                        calc_start_d = 1'b1;
                        state_d      = ISSUE;
                    end else if (y_q < c_y_last) begin
                        x_d          = '0;
                        y_d          = y_q + Y_W'(1);
                        w_step_cmd   = STEP_NEXT_LINE;
                        calc_start_d = 1'b1;
                        state_d      = ISSUE;
                    end else begin
                        frame_done_d = 1'b1;
                        state_d      = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q      <= IDLE;
            x_q          <= '0;
            y_q          <= '0;
            calc_start_q <= 1'b0;
            pix_valid_q  <= 1'b0;
            pix_x_q      <= '0;
            pix_y_q      <= '0;
            pix_depth_q  <= '0;
            pix_sof_q    <= 1'b0;
            pix_eol_q    <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            calc_start_q <= calc_start_d;
            pix_valid_q  <= pix_valid_d;
            pix_x_q      <= pix_x_d;
            pix_y_q      <= pix_y_d;
            pix_depth_q  <= pix_depth_d;
            pix_sof_q    <= pix_sof_d;
            pix_eol_q    <= pix_eol_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    coord_stepper u_coord_stepper (
        .clk         (sysclk),
        .rst         (reset),
        .i_cmd       (w_step_cmd),
        .i_re_origin (re_origin),
        .i_im_origin (im_origin),
        .i_step      (step),
        .o_re_acc    (w_re_acc),
        .o_im_acc    (w_im_acc)
    );

    // ------------------------------------------------------------------
    // Optional frame cycle counter
    // ------------------------------------------------------------------
`ifdef PIXEL_SCHED_PERF_EN
    logic [31:0] cyc_cnt_q, cyc_cnt_d;
    logic [31:0] frame_cycles_q, frame_cycles_d;

    always_comb begin
        cyc_cnt_d      = cyc_cnt_q;
        frame_cycles_d = frame_cycles_q;
        if (w_frame_accept) begin
            cyc_cnt_d = '0;
        end else if (busy_q) begin
            cyc_cnt_d = cyc_cnt_q + 32'd1;
        end
        // Includes the final EMIT cycle so the result lines up with frame_done
        if (frame_done_d) begin
            frame_cycles_d = cyc_cnt_d;
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            cyc_cnt_q      <= '0;
            frame_cycles_q <= '0;
        end else begin
            cyc_cnt_q      <= cyc_cnt_d;
            frame_cycles_q <= frame_cycles_d;
        end
    end

    assign frame_cycles = frame_cycles_q;
`else
    logic w_accept_unused;
    assign w_accept_unused = w_frame_accept;
    assign frame_cycles    = '0;
`endif

    // ------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------
    assign sched_if.calc_start = calc_start_q;
    assign sched_if.calc_x     = x_q;
    assign sched_if.calc_y     = y_q;
    assign sched_if.calc_re_c  = w_re_acc;
    assign sched_if.calc_im_c  = w_im_acc;
    assign sched_if.pix_valid  = pix_valid_q;
    assign sched_if.pix_x      = pix_x_q;
    assign sched_if.pix_y      = pix_y_q;
    assign sched_if.pix_depth  = pix_depth_q;
    assign sched_if.pix_sof    = pix_sof_q;
    assign sched_if.pix_eol    = pix_eol_q;
    assign busy                = busy_q;
    assign frame_done          = frame_done_q;

endmodule
`default_nettype wire
